// File: rtl/inst_mem_loader.sv
// Boot loader: parses a [count][words][xor] byte stream into instruction-memory
// writes at TEXT_BASE and holds the CPU in reset until a verified image is loaded.
module inst_mem_loader #(
    parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_data,
    output logic        o_in_ready,
    input  logic        i_reload,
    output logic        o_im_we,
    output logic [31:0] o_im_addr,
    output logic [31:0] o_im_wdata,
    output logic        o_cpu_rst,
    output logic        o_done,
    output logic        o_err,
    output logic [2:0]  o_state
);
    // Stream handshake: a byte moves on a rising edge where i_in_valid && o_in_ready.
    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,
        S_HDR1 = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [31:0] MAX_W = MAX_WORDS;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_count;
    logic [15:0] r_idx;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_shift;
    logic [7:0]  r_xor;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_accept;
    logic [15:0] w_hdr_n;
    logic        w_last_word;

    assign w_accept    = i_in_valid && o_in_ready;
    assign w_hdr_n     = {r_count[15:8], i_in_data};
    assign w_last_word = ({1'b0, r_idx} + 17'd1) == {1'b0, r_count};

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_HDR0;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HDR0: if (w_accept) w_state_nxt = S_HDR1;
            S_HDR1: begin
                if (w_accept) begin
                    if ({16'd0, w_hdr_n} > MAX_W) w_state_nxt = S_ERR;
                    else if (w_hdr_n == 16'd0)    w_state_nxt = S_CSUM;
                    else                          w_state_nxt = S_DATA;
                end
            end
            S_DATA: if (w_accept && r_byte_cnt == 2'd3 && w_last_word) w_state_nxt = S_CSUM;
            S_CSUM: if (w_accept) w_state_nxt = (i_in_data == r_xor) ? S_DONE : S_ERR;
            S_DONE, S_ERR: if (i_reload) w_state_nxt = S_HDR0;
            default: w_state_nxt = S_HDR0;
        endcase
    end

    // Status outputs decode the state register directly, so they are registered.
    always_comb begin
        o_in_ready = 1'b0;
        o_done     = 1'b0;
        o_err      = 1'b0;
        o_cpu_rst  = 1'b1;
        case (r_state)
            S_HDR0, S_HDR1, S_DATA, S_CSUM: o_in_ready = !i_rst;
            S_DONE: begin
                o_done    = 1'b1;
                o_cpu_rst = 1'b0;
            end
            S_ERR:   o_err = 1'b1;
            default: o_in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count    <= 16'd0;
            r_idx      <= 16'd0;
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'd0;
            r_xor      <= 8'd0;
            r_we       <= 1'b0;
            r_addr     <= TEXT_BASE;
            r_wdata    <= 32'd0;
        end else begin
            r_we <= 1'b0;
            if (w_accept) r_xor <= r_xor ^ i_in_data;
            case (r_state)
                S_HDR0: begin
                    r_idx      <= 16'd0;
                    r_byte_cnt <= 2'd0;
                    if (w_accept) r_count[15:8] <= i_in_data;
                end
                S_HDR1: if (w_accept) r_count[7:0] <= i_in_data;
                S_DATA: begin
                    if (w_accept) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_we    <= 1'b1;
                            r_addr  <= TEXT_BASE + {14'd0, r_idx, 2'b00};
                            r_wdata <= {r_shift, i_in_data};
                            r_idx   <= r_idx + 16'd1;
                        end else begin
                            r_shift <= {r_shift[15:0], i_in_data};
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (i_reload) begin
                        r_idx      <= 16'd0;
                        r_byte_cnt <= 2'd0;
                        r_xor      <= 8'd0;
                    end
                end
                default: r_we <= 1'b0;
            endcase
        end
    end

    assign o_im_we    = r_we;
    assign o_im_addr  = r_addr;
    assign o_im_wdata = r_wdata;
    assign o_state    = r_state;
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: scoreboard of expected memory writes plus
// status checks around checksum, oversize header, reset and reload.
module tb_inst_mem_loader;
    localparam logic [31:0] TB_BASE = 32'h0000_3000;
    localparam logic [2:0]  ST_HDR0 = 3'd0;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_in_valid = 1'b0;
    logic [7:0]  i_in_data = 8'd0;
    logic        o_in_ready;
    logic        i_reload = 1'b0;
    logic        o_im_we;
    logic [31:0] o_im_addr;
    logic [31:0] o_im_wdata;
    logic        o_cpu_rst;
    logic        o_done;
    logic        o_err;
    logic [2:0]  o_state;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    inst_mem_loader #(.TEXT_BASE(TB_BASE), .MAX_WORDS(1024)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .i_in_data(i_in_data),
        .o_in_ready(o_in_ready), .i_reload(i_reload), .o_im_we(o_im_we),
        .o_im_addr(o_im_addr), .o_im_wdata(o_im_wdata), .o_cpu_rst(o_cpu_rst),
        .o_done(o_done), .o_err(o_err), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the head of the expected queue.
    always @(negedge i_clk) begin
        if (o_im_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", o_im_addr, o_im_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({o_im_addr, o_im_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr %h data %h expected addr %h data %h",
                             o_im_addr, o_im_wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge
    // that follows the accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  waited;
        bit  acc;
        waited = 0;
        acc = 1'b0;
        if (gaps) begin
            i_in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
        end
        i_in_valid = 1'b1;
        i_in_data  = b;
        while (!acc) begin
            acc = o_in_ready;
            @(negedge i_clk);
            if (!acc) begin
                waited++;
                if (waited > 20) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: got no accept for byte %h expected accept", b);
                    i_in_valid = 1'b0;
                    return;
                end
            end
        end
        i_in_valid = 1'b0;
    endtask

    task automatic send_image(input logic [7:0] csum, input bit gaps);
        send_byte(8'h00, gaps);
        send_byte(8'h02, gaps);
        exp_q.push_back({TB_BASE, 32'h3C01_0000});
        send_byte(8'h3C, gaps); send_byte(8'h01, gaps);
        send_byte(8'h00, gaps); send_byte(8'h00, gaps);
        exp_q.push_back({TB_BASE + 32'd4, 32'h3421_0001});
        send_byte(8'h34, gaps); send_byte(8'h21, gaps);
        send_byte(8'h00, gaps); send_byte(8'h01, gaps);
        send_byte(csum, gaps);
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done"}, {31'd0, o_done}, 32'd1);
        chk({tag, "_err"}, {31'd0, o_err}, 32'd0);
        chk({tag, "_cpu_rst"}, {31'd0, o_cpu_rst}, 32'd0);
        chk({tag, "_ready"}, {31'd0, o_in_ready}, 32'd0);
        chk({tag, "_q_empty"}, exp_q.size(), 32'd0);
    endtask

    task automatic do_reload(input string tag);
        i_reload = 1'b1;
        @(negedge i_clk);
        i_reload = 1'b0;
        chk({tag, "_state"}, {29'd0, o_state}, {29'd0, ST_HDR0});
        chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
        chk({tag, "_err"}, {31'd0, o_err}, 32'd0);
        chk({tag, "_cpu_rst"}, {31'd0, o_cpu_rst}, 32'd1);
        chk({tag, "_ready"}, {31'd0, o_in_ready}, 32'd1);
    endtask

    initial begin
        // Reset values.
        repeat (3) @(negedge i_clk);
        chk("rst_ready", {31'd0, o_in_ready}, 32'd0);
        chk("rst_we", {31'd0, o_im_we}, 32'd0);
        chk("rst_addr", o_im_addr, TB_BASE);
        chk("rst_wdata", o_im_wdata, 32'd0);
        chk("rst_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        i_rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, o_in_ready}, 32'd1);
        @(negedge i_clk);

        send_image(8'h2B, 1'b0);
        check_done("normal");

        do_reload("reload1");
        send_image(8'h2A, 1'b0);
        chk("badcsum_err", {31'd0, o_err}, 32'd1);
        chk("badcsum_done", {31'd0, o_done}, 32'd0);
        chk("badcsum_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
        chk("badcsum_ready", {31'd0, o_in_ready}, 32'd0);

        do_reload("reload2");
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check_done("empty");

        do_reload("reload3");
        send_byte(8'h04, 1'b0);
        send_byte(8'h01, 1'b0);
        chk("oversize_err", {31'd0, o_err}, 32'd1);
        chk("oversize_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
        i_in_valid = 1'b1;
        i_in_data  = 8'hAA;
        for (int k = 0; k < 4; k++) begin
            chk("oversize_no_accept", {31'd0, o_in_ready}, 32'd0);
            @(negedge i_clk);
        end
        i_in_valid = 1'b0;
        chk("oversize_err_hold", {31'd0, o_err}, 32'd1);

        do_reload("reload4");
        send_image(8'h2B, 1'b1);
        check_done("gaps");

        // Reset mid-word: the partial word must never be written.
        do_reload("reload5");
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h01, 1'b0);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("midrst_ready", {31'd0, o_in_ready}, 32'd0);
        chk("midrst_addr", o_im_addr, TB_BASE);
        chk("midrst_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
        i_rst = 1'b0;
        @(negedge i_clk);
        send_image(8'h2B, 1'b0);
        check_done("after_rst");

        do_reload("reload6");
        send_image(8'h2B, 1'b0);
        check_done("reload_img");

        repeat (3) @(negedge i_clk);
        chk("final_q_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Hardware boot loader that fills instruction memory from a byte stream, standing in for the simulation-only `$readmemh` preload on real hardware. It sits between an external byte source (UART receiver or debug bridge) and the instruction-memory write port. It holds the CPU in reset until a complete, checksum-verified program image has been written starting at the text base address.

## Interface
- `TEXT_BASE`, default 32'h0000_3000: byte address of the first instruction word.
- `MAX_WORDS`, default 1024: instruction memory capacity in words; the header word count must not exceed it.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: `in_data` holds a byte.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle.
- `reload` in 1: one-cycle pulse that restarts loading from DONE or ERR.
- `im_we` out 1: instruction-memory write enable, one-cycle pulse per word.
- `im_addr` out 32: byte address of the write.
- `im_wdata` out 32: word to write.
- `cpu_rst` out 1: reset for the CPU; high while not DONE.
- `done` out 1: image loaded and verified.
- `err` out 1: load failed.

## Operation
- A byte is accepted on a rising edge where `in_valid && in_ready` is true. Nothing else consumes stream bytes.
- Stream format, in order:
  - 2-byte word count N, big-endian.
  - N words of 4 bytes each, big-endian; the first byte goes to bits [31:24], matching hex-file order.
  - 1 checksum byte equal to the XOR of every preceding byte, header included.
- States and transitions:
  - HDR0: accept count high byte, go to HDR1.
  - HDR1: accept count low byte.
    - N > MAX_WORDS: go to ERR.
    - N == 0: go to CSUM.
    - Otherwise go to DATA.
  - DATA: shift in bytes. On every 4th byte, register the word and word index i, pulse the write, then increment i. After word N-1 is accepted, go to CSUM.
  - CSUM: accept one byte. If it equals the running XOR, go to DONE; otherwise go to ERR.
  - DONE: `done`=1, `cpu_rst`=0, `in_ready`=0. A `reload` pulse returns to HDR0.
  - ERR: `err`=1, `cpu_rst`=1, `in_ready`=0. A `reload` pulse returns to HDR0.
- Write address: `im_addr` = TEXT_BASE + 4*i. Arithmetic is 32-bit and wraps silently. Word count N is 16 bits. Index i is 16 bits and is cleared in HDR0.
- `in_ready` = 1 in HDR0, HDR1, DATA and CSUM, and is gated low while `rst`=1.
- `reload` is ignored outside DONE and ERR. Taking `reload` clears i, the byte counter, the XOR accumulator, `done` and `err`.
- `rst` clears the same items as `reload` at any point, including mid-word or mid-image, and sets state to HDR0. Memory contents already written are not cleared. A partially assembled word is discarded and no write is issued for it.

## Timing
- Reset values:
  - state HDR0.
  - `im_we`=0, `im_addr`=TEXT_BASE, `im_wdata`=0.
  - `cpu_rst`=1, `done`=0, `err`=0.
  - `in_ready`=0 during `rst`, 1 on the first cycle after `rst` deasserts.
- All outputs except `in_ready` are registered.
- Write latency: `im_we` is high for exactly the one cycle after the edge that accepted the word's 4th byte. `im_addr` and `im_wdata` are valid in that same cycle and hold until the next write.
- Checksum decision: `done` or `err` rises on the cycle after the edge that accepted the checksum byte. On a pass, `cpu_rst` falls in that same cycle.
- ERR on an oversize count asserts on the cycle after the second header byte. No data bytes are accepted after that.
- `reload` taken at edge t: state is HDR0 and `in_ready`=1 at t+1. `cpu_rst`=1 and `done`=`err`=0 from t+1.
- Gaps in `in_valid` stall progress only. Results are identical with or without gaps.

## Test plan
- Normal load:
  - Stimulus: bytes 00 02, 3C 01 00 00, 34 21 00 01, checksum 2B, with `in_valid` held high.
  - Expect two `im_we` pulses: 0x3C010000 @0x3000, then 0x34210001 @0x3004.
  - Expect `done`=1 and `cpu_rst`=0 one cycle after the checksum byte.
- Bad checksum:
  - Stimulus: the same image with checksum 2A.
  - Expect both writes, then `err`=1, `cpu_rst` held at 1, `in_ready`=0.
- Empty image:
  - Stimulus: 00 00 00.
  - Expect no `im_we`, and `done`=1 after the third byte.
- Oversize count:
  - Stimulus: header 04 01 (N=1025, MAX_WORDS=1024).
  - Expect `err`=1 the cycle after byte 2, and following bytes not accepted.
- Backpressure and gaps:
  - Stimulus: the normal-load image with `in_valid` randomly deasserted.
  - Expect the same writes, addresses and `done` as the normal load.
- Reset and reload:
  - Stimulus: assert `rst` after 2 bytes of word 1, then send the full normal image.
  - Expect writes only at 0x3000 and 0x3004, and `done`=1.
  - Then pulse `reload` and resend the image: expect `done` low at the next cycle and the same two writes.
